// File: rtl/mem_stage_pkg.sv
// Shared widths, load-op encodings and exception codes for the MEM pipeline stage.
// The packed bus layouts below are the contract with the EX and WB stages.
package mem_stage_pkg;

   localparam int TLB_IDX_W_DEF = 4;

   // to_MEM_data, MSB first:
   //   pc[31:0] dest[4:0] alu_result[31:0] gr_we mem_req is_load ld_op[2:0]
   //   ex_INT ex_SYS ex_BRK ex_ADEF ex_ALE ex_INE is_ertn op_csr csr_num[13:0]
   //   csr_we csr_wmask[31:0] rj[4:0] tlbsrch_en data_tlb_found data_tlb_index
   localparam int TO_MEM_BASE_W = 137;

   // Bit distance from the top of to_MEM_data down to mem_req (pc+dest+alu_result+gr_we+1).
   localparam int MEM_REQ_OFS   = 71;

   // to_WB_data, MSB first:
   //   pc dest final_result gr_we ex_INT ex_SYS ex_BRK ex_ADEF ex_ALE ex_INE is_ertn
   //   op_csr csr_num csr_we csr_wmask rj tlbsrch_en data_tlb_found data_tlb_index
   localparam int TO_WB_BASE_W  = 132;

   // MEM_forward = {dest, result, op_csr, load_wait}; this width excludes load_wait.
   localparam int FORWRD_DATA_W = 38;

   typedef enum logic [2:0] {
      LD_B  = 3'd0,
      LD_BU = 3'd1,
      LD_H  = 3'd2,
      LD_HU = 3'd3,
      LD_W  = 3'd4
   } ld_op_e;

   localparam logic [5:0] ECODE_INT  = 6'h00;
   localparam logic [5:0] ECODE_ADEF = 6'h08;
   localparam logic [5:0] ECODE_ALE  = 6'h09;
   localparam logic [5:0] ECODE_SYS  = 6'h0b;
   localparam logic [5:0] ECODE_BRK  = 6'h0c;
   localparam logic [5:0] ECODE_INE  = 6'h0d;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: selects byte/half/word from the SRAM read word by address and extends it.
module mem_stage_load_align
   import mem_stage_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  addr_i,
   input  ld_op_e      ld_op_i,
   output logic [31:0] result_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata_i[{addr_i, 3'b000} +: 8];
      half_sel = rdata_i[{addr_i[1], 4'b0000} +: 16];
      case (ld_op_i)
         LD_B:    result_o = {{24{byte_sel[7]}}, byte_sel};
         LD_BU:   result_o = {24'd0, byte_sel};
         LD_H:    result_o = {{16{half_sel[15]}}, half_sel};
         LD_HU:   result_o = {16'd0, half_sel};
         default: result_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds the EX instruction until its data-SRAM response arrives, aligns load
// data, passes exception/CSR/TLB fields to WB and drops responses that belong to flushed requests.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int TLB_IDX_W = TLB_IDX_W_DEF,
   parameter int DISCARD_W = 2
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              flush,
   input  logic                              EX_to_MEM_valid,
   input  logic [TO_MEM_BASE_W+TLB_IDX_W-1:0] to_MEM_data,
   output logic                              MEM_allow_in,
   input  logic                              data_sram_data_ok,
   input  logic [31:0]                       data_sram_rdata,
   output logic                              MEM_to_WB_valid,
   output logic [TO_WB_BASE_W+TLB_IDX_W-1:0] to_WB_data,
   input  logic                              WB_allow_in,
   output logic [FORWRD_DATA_W:0]            MEM_forward,
   output logic                              mem_ex_hint
);

   localparam int TO_MEM_W    = TO_MEM_BASE_W + TLB_IDX_W;
   localparam int MEM_REQ_POS = TO_MEM_W - MEM_REQ_OFS;

   logic                 mem_valid_q,    mem_valid_d;
   logic [TO_MEM_W-1:0]  bus_q,          bus_d;
   logic                 resp_pending_q, resp_pending_d;
   logic                 buf_valid_q,    buf_valid_d;
   logic [31:0]          rdata_buf_q,    rdata_buf_d;
   logic [DISCARD_W-1:0] discard_cnt_q,  discard_cnt_d;

   logic [31:0]          r_pc, r_alu, r_csr_wmask;
   logic [4:0]           r_dest, r_rj;
   logic                 r_gr_we, r_mem_req, r_is_load;
   logic [2:0]           r_ld_op;
   logic                 r_ex_int, r_ex_sys, r_ex_brk, r_ex_adef, r_ex_ale, r_ex_ine;
   logic                 r_ertn, r_op_csr, r_csr_we, r_tlbsrch, r_tlb_found;
   logic [13:0]          r_csr_num;
   logic [TLB_IDX_W-1:0] r_tlb_idx;

   logic                 use_ok, mem_ready_go, mem_leave, entry, load_wait;
   logic [31:0]          ld_src, ld_result, final_result;

   assign {r_pc, r_dest, r_alu, r_gr_we, r_mem_req, r_is_load, r_ld_op,
           r_ex_int, r_ex_sys, r_ex_brk, r_ex_adef, r_ex_ale, r_ex_ine,
           r_ertn, r_op_csr, r_csr_num, r_csr_we, r_csr_wmask, r_rj,
           r_tlbsrch, r_tlb_found, r_tlb_idx} = bus_q;

   // A data_ok only answers the current instruction once every stale response has been dropped.
   assign use_ok          = data_sram_data_ok & (discard_cnt_q == '0);
   assign mem_ready_go    = ~resp_pending_q | use_ok;
   assign MEM_allow_in    = ~mem_valid_q | (mem_ready_go & WB_allow_in);
   assign MEM_to_WB_valid = mem_valid_q & mem_ready_go & ~flush;
   assign mem_leave       = MEM_to_WB_valid & WB_allow_in;
   assign entry           = EX_to_MEM_valid & MEM_allow_in;

   assign ld_src = buf_valid_q ? rdata_buf_q : data_sram_rdata;

   mem_stage_load_align u_load_align (
      .rdata_i  (ld_src),
      .addr_i   (r_alu[1:0]),
      .ld_op_i  (ld_op_e'(r_ld_op)),
      .result_o (ld_result)
   );

   assign final_result = r_is_load ? ld_result : r_alu;
   assign load_wait    = mem_valid_q & r_is_load & ~mem_ready_go;

   assign to_WB_data = {r_pc, r_dest, final_result, r_gr_we,
                        r_ex_int, r_ex_sys, r_ex_brk, r_ex_adef, r_ex_ale, r_ex_ine,
                        r_ertn, r_op_csr, r_csr_num, r_csr_we, r_csr_wmask, r_rj,
                        r_tlbsrch, r_tlb_found, r_tlb_idx};

   assign MEM_forward = {r_dest & {5{mem_valid_q}}, final_result, r_op_csr & mem_valid_q, load_wait};

   assign mem_ex_hint = mem_valid_q & (r_ex_int | r_ex_sys | r_ex_brk | r_ex_adef |
                                       r_ex_ale | r_ex_ine | r_ertn);

   always_comb begin
      mem_valid_d    = mem_valid_q;
      bus_d          = bus_q;
      resp_pending_d = resp_pending_q;
      buf_valid_d    = buf_valid_q;
      rdata_buf_d    = rdata_buf_q;
      discard_cnt_d  = discard_cnt_q;

      if (entry) begin
         bus_d = to_MEM_data;
      end

      if (flush) begin
         mem_valid_d    = 1'b0;
         resp_pending_d = 1'b0;
         buf_valid_d    = 1'b0;
      end else begin
         if (MEM_allow_in) begin
            mem_valid_d = EX_to_MEM_valid;
         end
         if (entry) begin
            resp_pending_d = to_MEM_data[MEM_REQ_POS];
         end else if (resp_pending_q & use_ok) begin
            resp_pending_d = 1'b0;
         end
         // Hold the response if WB stalls, since the SRAM will not present it again.
         if (mem_leave) begin
            buf_valid_d = 1'b0;
         end else if (mem_valid_q & r_mem_req & resp_pending_q & use_ok & ~WB_allow_in) begin
            buf_valid_d = 1'b1;
            rdata_buf_d = data_sram_rdata;
         end
      end

      if (flush & resp_pending_q & ~data_sram_data_ok) begin
         if (~&discard_cnt_q) begin
            discard_cnt_d = discard_cnt_q + DISCARD_W'(1);
         end
      end else if (data_sram_data_ok & (discard_cnt_q != '0)) begin
         discard_cnt_d = discard_cnt_q - DISCARD_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_valid_q    <= 1'b0;
         bus_q          <= '0;
         resp_pending_q <= 1'b0;
         buf_valid_q    <= 1'b0;
         rdata_buf_q    <= '0;
         discard_cnt_q  <= '0;
      end else begin
         mem_valid_q    <= mem_valid_d;
         bus_q          <= bus_d;
         resp_pending_q <= resp_pending_d;
         buf_valid_q    <= buf_valid_d;
         rdata_buf_q    <= rdata_buf_d;
         discard_cnt_q  <= discard_cnt_d;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboarded bench for mem_stage: directed instructions push expected WB buses, a negedge
// monitor pops and compares them whenever the stage hands an instruction to WB.
module tb_mem_stage;
   import mem_stage_pkg::*;

   localparam int TW = 4;
   localparam int MW = TO_MEM_BASE_W + TW;
   localparam int WW = TO_WB_BASE_W + TW;

   typedef struct {
      logic [31:0] pc;
      logic [4:0]  dest;
      logic [31:0] alu;
      logic        gr_we, mem_req, is_load;
      logic [2:0]  ldop;
      logic [5:0]  ex;      // {INT,SYS,BRK,ADEF,ALE,INE}
      logic        ertn, op_csr;
      logic [13:0] csr_num;
      logic        csr_we;
      logic [31:0] wmask;
      logic [4:0]  rj;
      logic        tlbs, found;
      logic [3:0]  idx;
   } ins_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic flush = 1'b0;
   logic ex_valid = 1'b0;
   logic data_ok = 1'b0;
   logic wb_allow = 1'b1;
   logic [MW-1:0] to_mem = '0;
   logic [31:0]   rdata = '0;
   logic          allow_in, wb_valid, ex_hint;
   logic [WW-1:0] to_wb;
   logic [FORWRD_DATA_W:0] fwd;

   int n_tests = 0;
   int n_fail  = 0;
   logic [WW-1:0] exp_q[$];

   always #5 clk = ~clk;

   mem_stage #(.TLB_IDX_W(TW), .DISCARD_W(2)) dut (
      .clk               (clk),
      .reset             (reset),
      .flush             (flush),
      .EX_to_MEM_valid   (ex_valid),
      .to_MEM_data       (to_mem),
      .MEM_allow_in      (allow_in),
      .data_sram_data_ok (data_ok),
      .data_sram_rdata   (rdata),
      .MEM_to_WB_valid   (wb_valid),
      .to_WB_data        (to_wb),
      .WB_allow_in       (wb_allow),
      .MEM_forward       (fwd),
      .mem_ex_hint       (ex_hint)
   );

   function automatic ins_t mk(input logic [31:0] pc, input logic [4:0] dest, input logic [31:0] alu);
      ins_t i;
      i.pc = pc; i.dest = dest; i.alu = alu; i.gr_we = 1'b1; i.mem_req = 1'b0; i.is_load = 1'b0;
      i.ldop = LD_W; i.ex = 6'd0; i.ertn = 1'b0; i.op_csr = 1'b0; i.csr_num = 14'd0; i.csr_we = 1'b0;
      i.wmask = 32'd0; i.rj = dest ^ 5'h1f; i.tlbs = 1'b0; i.found = 1'b0; i.idx = 4'd0;
      return i;
   endfunction

   function automatic ins_t mk_ld(input logic [31:0] pc, input logic [4:0] dest, input logic [31:0] addr,
                                  input logic [2:0] ldop);
      ins_t i;
      i = mk(pc, dest, addr);
      i.mem_req = 1'b1; i.is_load = 1'b1; i.ldop = ldop;
      return i;
   endfunction

   function automatic logic [MW-1:0] pack_mem(input ins_t i);
      return {i.pc, i.dest, i.alu, i.gr_we, i.mem_req, i.is_load, i.ldop, i.ex, i.ertn, i.op_csr,
              i.csr_num, i.csr_we, i.wmask, i.rj, i.tlbs, i.found, i.idx};
   endfunction

   function automatic logic [WW-1:0] pack_wb(input ins_t i, input logic [31:0] fin);
      return {i.pc, i.dest, fin, i.gr_we, i.ex, i.ertn, i.op_csr,
              i.csr_num, i.csr_we, i.wmask, i.rj, i.tlbs, i.found, i.idx};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present an instruction until MEM accepts it; returns #1 after the accepting edge.
   task automatic issue(input ins_t i, input logic [31:0] fin, input bit expect_out);
      bit ok;
      ok = 1'b0;
      to_mem   = pack_mem(i);
      ex_valid = 1'b1;
      if (expect_out) exp_q.push_back(pack_wb(i, fin));
      for (int k = 0; k < 20 && !ok; k++) begin
         @(negedge clk);
         ok = allow_in;
      end
      chk("issue_accept", {31'd0, ok}, 32'd1);
      step();
      ex_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!reset && wb_valid && wb_allow) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL wb_unexpected: got %h expected none", to_wb);
         end else begin
            logic [WW-1:0] e;
            e = exp_q.pop_front();
            if (to_wb !== e) begin
               n_fail++;
               $display("FAIL wb_bus: got %h expected %h", to_wb, e);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [2:0]  ldop;
      logic [31:0] addr;
      logic [31:0] rd;
      logic [31:0] exp;
   } ld_vec_t;

   ld_vec_t vecs[6] = '{
      '{LD_B,  32'h0000_4000, 32'h0000_007F, 32'h0000_007F},
      '{LD_BU, 32'h0000_4003, 32'hAB00_0000, 32'h0000_00AB},
      '{LD_H,  32'h0000_4002, 32'h8001_0000, 32'hFFFF_8001},
      '{LD_HU, 32'h0000_4000, 32'h0000_FFFE, 32'h0000_FFFE},
      '{LD_W,  32'h0000_4000, 32'hCAFE_F00D, 32'hCAFE_F00D},
      '{LD_B,  32'h0000_4002, 32'h00F0_0000, 32'hFFFF_FFF0}
   };

   initial begin
      ins_t i;

      // reset state
      repeat (2) step();
      @(negedge clk);
      chk("rst_allow_in", {31'd0, allow_in}, 32'd1);
      chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
      chk("rst_hint",     {31'd0, ex_hint},  32'd0);
      chk("rst_fwd_dest", {27'd0, fwd[38:34]}, 32'd0);
      step();
      reset = 1'b0;

      // 1: ALU op passes in one cycle
      i = mk(32'h1c00_0000, 5'd3, 32'h0000_1234);
      issue(i, 32'h0000_1234, 1'b1);
      @(negedge clk);
      chk("t1_wb_valid", {31'd0, wb_valid}, 32'd1);
      chk("t1_allow_in", {31'd0, allow_in}, 32'd1);
      chk("t1_fwd_dest", {27'd0, fwd[38:34]}, 32'd3);
      chk("t1_fwd_result", fwd[33:2], 32'h0000_1234);
      step();
      @(negedge clk);
      chk("t1_drained", {31'd0, wb_valid}, 32'd0);
      step();

      // 2: ld.b, response after 3 waiting cycles
      i = mk_ld(32'h1c00_0010, 5'd4, 32'h0000_1001, LD_B);
      issue(i, 32'hFFFF_FF80, 1'b1);
      repeat (3) begin
         @(negedge clk);
         chk("t2_load_wait", {31'd0, fwd[0]}, 32'd1);
         step();
      end
      rdata = 32'h0000_8000;
      data_ok = 1'b1;
      @(negedge clk);
      chk("t2_load_wait_clr", {31'd0, fwd[0]}, 32'd0);
      chk("t2_wb_valid", {31'd0, wb_valid}, 32'd1);
      step();
      data_ok = 1'b0;
      rdata = 32'd0;

      // 3: ld.hu with WB stalled on data_ok; result must come from the buffer
      wb_allow = 1'b0;
      i = mk_ld(32'h1c00_0020, 5'd5, 32'h0000_2002, LD_HU);
      issue(i, 32'h0000_BEEF, 1'b1);
      rdata = 32'hBEEF_0000;
      data_ok = 1'b1;
      @(negedge clk);
      chk("t3_valid_stalled", {31'd0, wb_valid}, 32'd1);
      chk("t3_allow_in_stalled", {31'd0, allow_in}, 32'd0);
      step();
      data_ok = 1'b0;
      rdata = 32'h1234_5678;
      repeat (2) begin
         @(negedge clk);
         chk("t3_valid_held", {31'd0, wb_valid}, 32'd1);
         chk("t3_buf_result", fwd[33:2], 32'h0000_BEEF);
         step();
      end
      wb_allow = 1'b1;
      @(negedge clk);
      chk("t3_allow_in_release", {31'd0, allow_in}, 32'd1);
      step();
      rdata = 32'd0;

      // 4: flush while pending; the stale response is dropped
      i = mk_ld(32'h1c00_0030, 5'd6, 32'h0000_3000, LD_W);
      issue(i, 32'd0, 1'b0);
      flush = 1'b1;
      @(negedge clk);
      chk("t4_flush_valid", {31'd0, wb_valid}, 32'd0);
      step();
      flush = 1'b0;
      i = mk_ld(32'h1c00_0040, 5'd7, 32'h0000_3004, LD_W);
      issue(i, 32'h0000_5A5A, 1'b1);
      @(negedge clk);
      chk("t4_wait_b", {31'd0, fwd[0]}, 32'd1);
      step();
      data_ok = 1'b1;
      rdata = 32'h0000_DEAD;
      @(negedge clk);
      chk("t4_stale_dropped", {31'd0, wb_valid}, 32'd0);
      chk("t4_stale_wait", {31'd0, fwd[0]}, 32'd1);
      step();
      rdata = 32'h0000_5A5A;
      @(negedge clk);
      chk("t4_delivered", {31'd0, wb_valid}, 32'd1);
      step();
      data_ok = 1'b0;
      rdata = 32'd0;

      // 5: exception pass-through and field order
      i = mk(32'h1c00_0050, 5'd9, 32'h0000_0003);
      i.ex = 6'b000010; i.op_csr = 1'b1; i.csr_num = 14'h0abc; i.csr_we = 1'b1;
      i.wmask = 32'hF0F0_A5A5; i.tlbs = 1'b1; i.found = 1'b0; i.idx = 4'hA;
      issue(i, 32'h0000_0003, 1'b1);
      @(negedge clk);
      chk("t5_hint", {31'd0, ex_hint}, 32'd1);
      chk("t5_ready", {31'd0, wb_valid}, 32'd1);
      chk("t5_fwd_op_csr", {31'd0, fwd[1]}, 32'd1);
      step();
      @(negedge clk);
      chk("t5_hint_clr", {31'd0, ex_hint}, 32'd0);
      step();
      i = mk(32'h1c00_0054, 5'd0, 32'h0000_0000);
      i.ertn = 1'b1; i.gr_we = 1'b0; i.idx = 4'h5; i.found = 1'b1;
      issue(i, 32'h0000_0000, 1'b1);
      @(negedge clk);
      chk("t5_ertn_hint", {31'd0, ex_hint}, 32'd1);
      step();

      // load extract table, response in the first MEM cycle
      for (int v = 0; v < 6; v++) begin
         i = mk_ld(32'h1c00_0100 + 32'(v * 4), 5'(v + 10), vecs[v].addr, vecs[v].ldop);
         issue(i, vecs[v].exp, 1'b1);
         rdata = vecs[v].rd;
         data_ok = 1'b1;
         @(negedge clk);
         chk("tbl_ready", {31'd0, wb_valid}, 32'd1);
         step();
         data_ok = 1'b0;
         rdata = 32'd0;
      end

      // 6: reset while a load is pending and a stale response is owed
      i = mk_ld(32'h1c00_0200, 5'd20, 32'h0000_5000, LD_W);
      issue(i, 32'd0, 1'b0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      i = mk_ld(32'h1c00_0204, 5'd21, 32'h0000_5004, LD_W);
      issue(i, 32'd0, 1'b0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      @(negedge clk);
      chk("t6_allow_in", {31'd0, allow_in}, 32'd1);
      chk("t6_wb_valid", {31'd0, wb_valid}, 32'd0);
      chk("t6_hint", {31'd0, ex_hint}, 32'd0);
      chk("t6_fwd_dest", {27'd0, fwd[38:34]}, 32'd0);
      chk("t6_load_wait", {31'd0, fwd[0]}, 32'd0);
      step();
      i = mk_ld(32'h1c00_0208, 5'd22, 32'h0000_5008, LD_W);
      issue(i, 32'h1357_9BDF, 1'b1);
      rdata = 32'h1357_9BDF;
      data_ok = 1'b1;
      @(negedge clk);
      chk("t6_no_stale_discard", {31'd0, wb_valid}, 32'd1);
      step();
      data_ok = 1'b0;
      rdata = 32'd0;

      repeat (2) step();
      chk("sb_empty", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
